// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule definitions: S-box, round constants, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package aes_key_pkg;

    localparam int NR    = 10;   // AES-128 rounds
    localparam int NK    = 4;    // 32-bit words per cipher key
    localparam int KEY_W = 128;  // cipher key / round key width

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_e;

    // FIPS-197 forward S-box, indexed by input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8); walks the round constant 01,02,..,80,1B,36.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_expansion_seq_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of the input).
// Ports: word_i - input word; word_o - byte-wise substituted word.
module sub_word
    import aes_key_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                     SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-slot store.
// Latency: start to done is 10 cycles; k0 valid 1 cycle after start edge, k1 after 2.
// Backpressure: none; start is ignored while busy, accepted whenever IDLE.
// Ports: clk, asy_reset (async active-high), start/key_in request, rd_idx select;
//        busy, done pulse, keys_valid, k0/k1 direct slots, rd_key indexed read.
// Optional: define KEY_EXP_ZEROIZE_EN to add a synchronous zeroize input that
//           clears all key material and returns to IDLE (priority over start).
module key_expansion_seq
    import aes_key_pkg::*;
(
    input  logic             clk,
    input  logic             asy_reset,
`ifdef KEY_EXP_ZEROIZE_EN
    input  logic             zeroize,
`endif
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic [3:0]       rd_idx,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    output logic [KEY_W-1:0] k0,
    output logic [KEY_W-1:0] k1,
    output logic [KEY_W-1:0] rd_key
);

    state_e           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             done_q, done_d;
    logic             keys_valid_q, keys_valid_d;
    logic [KEY_W-1:0] slot_q [NR+1];
    logic [KEY_W-1:0] slot_d [NR+1];

    logic [KEY_W-1:0] prev_key;
    logic [KEY_W-1:0] next_key;
    logic [31:0]      rot_word;
    logic [31:0]      sub_out;
    logic [31:0]      temp;
    logic [31:0]      nw0, nw1, nw2, nw3;

    // Round rnd_q derives its key from the slot written on the previous edge.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < NR; i++) begin
            if (rnd_q == 4'(i + 1)) prev_key = slot_q[i];
        end
    end

    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    sub_word u_sub_word (
        .word_i (rot_word),
        .word_o (sub_out)
    );

    assign temp     = sub_out ^ {rcon_q, 24'h0};
    assign nw0      = prev_key[127:96] ^ temp;
    assign nw1      = prev_key[95:64]  ^ nw0;
    assign nw2      = prev_key[63:32]  ^ nw1;
    assign nw3      = prev_key[31:0]   ^ nw2;
    assign next_key = {nw0, nw1, nw2, nw3};

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        rcon_d       = rcon_q;
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;
        slot_d       = slot_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    slot_d[0]    = key_in;
                    rnd_d        = 4'd1;
                    rcon_d       = 8'h01;
                    keys_valid_d = 1'b0;
                    state_d      = EXPAND;
                end
            end
            EXPAND: begin
                for (int i = 1; i <= NR; i++) begin
                    if (rnd_q == 4'(i)) slot_d[i] = next_key;
                end
                rcon_d = xtime(rcon_q);
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == 4'(NR)) begin
                    state_d      = IDLE;
                    rnd_d        = 4'd0;
                    done_d       = 1'b1;
                    keys_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef KEY_EXP_ZEROIZE_EN
        // Evaluated last so it overrides start and any in-flight round.
        if (zeroize) begin
            for (int i = 0; i <= NR; i++) slot_d[i] = '0;
            state_d      = IDLE;
            rnd_d        = 4'd0;
            rcon_d       = 8'h00;
            done_d       = 1'b0;
            keys_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge asy_reset) begin
        if (asy_reset) begin
            state_q      <= IDLE;
            rnd_q        <= 4'd0;
            rcon_q       <= 8'h00;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            for (int i = 0; i <= NR; i++) slot_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            rcon_q       <= rcon_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
            for (int i = 0; i <= NR; i++) slot_q[i] <= slot_d[i];
        end
    end

    // Out-of-range indices 11..15 read as zero.
    always_comb begin
        rd_key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rd_idx == 4'(i)) rd_key = slot_q[i];
        end
    end

    assign busy       = (state_q == EXPAND);
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign k0         = slot_q[0];
    assign k1         = slot_q[1];

endmodule

// File: tb/tb_key_expansion_seq.sv
module tb_key_expansion_seq;

    logic         clk = 1'b0;
    logic         asy_reset;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   rd_idx;
    logic         busy, done, keys_valid;
    logic [127:0] k0, k1, rd_key;
`ifdef KEY_EXP_ZEROIZE_EN
    logic         zeroize;
`endif

    always #5 clk = ~clk;

    key_expansion_seq dut (
        .clk        (clk),
        .asy_reset  (asy_reset),
`ifdef KEY_EXP_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .start      (start),
        .key_in     (key_in),
        .rd_idx     (rd_idx),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .k0         (k0),
        .k1         (k1),
        .rd_key     (rd_key)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // ---------------- reference model ----------------
    logic [7:0]   sbox_tab [256];
    logic [127:0] model_rk [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] b = 8'(v);
            logic [7:0] inv = 8'h00;
            if (b != 8'h00) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, b);
            end
            sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // Word-at-a-time FIPS-197 expansion into 44 words.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Entered just after a negedge; returns at the negedge where done is seen
    // (or after a 20-cycle bound). cyc counts edges after the start edge.
    task automatic run_expand(input string name, input logic [127:0] key, output int cyc);
        model_expand(key);
        start = 1'b1;
        key_in = key;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_k0"}, k0, key);
        chk1({name, "_busy"}, busy, 1'b1);
        chk1({name, "_kv_low"}, keys_valid, 1'b0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({name, "_k1_early"}, k1, model_rk[1]);
        end
    endtask

    // Reads every slot against the model; slots are stable while idle.
    task automatic verify_slots(input string name);
        for (int r = 0; r < 11; r++) begin
            rd_idx = 4'(r);
            #1;
            chk($sformatf("%s_slot%0d", name, r), rd_key, model_rk[r]);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] k1;
        logic [127:0] k10;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc;
        int cnt0;
        logic [127:0] key_a, key_b;

        asy_reset = 1'b1;
        start = 1'b0;
        key_in = '0;
        rd_idx = 4'd0;
`ifdef KEY_EXP_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        build_sbox();
        repeat (2) @(negedge clk);

        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_kv", keys_valid, 1'b0);
        chk("rst_k0", k0, '0);
        chk("rst_k1", k1, '0);
        chk("rst_rdkey", rd_key, '0);
        asy_reset = 1'b0;
        @(negedge clk);

        // -------- vector table --------
        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{128'h0,
                    128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        for (int i = 2; i < 6; i++) begin
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
            model_expand(vecs[i].key);
            vecs[i].k1  = model_rk[1];
            vecs[i].k10 = model_rk[10];
        end

        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_expand(nm, vecs[i].key, cyc);
            chki({nm, "_latency"}, cyc, 10);
            chk1({nm, "_kv"}, keys_valid, 1'b1);
            chk1({nm, "_busy_end"}, busy, 1'b0);
            chk({nm, "_k1"}, k1, vecs[i].k1);
            rd_idx = 4'd10;
            #1;
            chk({nm, "_k10"}, rd_key, vecs[i].k10);
            @(negedge clk);
            chk1({nm, "_done_pulse"}, done, 1'b0);
            chk1({nm, "_kv_hold"}, keys_valid, 1'b1);
            verify_slots(nm);
            rd_idx = 4'(11 + $urandom_range(0, 4));
            #1;
            chk({nm, "_oob"}, rd_key, '0);
            rd_idx = 4'd12;
            #1;
            chk({nm, "_idx12"}, rd_key, '0);
            @(negedge clk);
        end

        // -------- start while busy is ignored --------
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = ~key_a;
        model_expand(key_a);
        start = 1'b1;
        key_in = key_a;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        key_in = key_b;
        @(negedge clk);
        start = 1'b0;
        cyc = 5;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chki("ign_latency", cyc, 10);
        @(negedge clk);
        verify_slots("ign");

        // -------- async reset mid-expansion --------
        start = 1'b1;
        key_in = key_b;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 asy_reset = 1'b1;
        rd_idx = 4'd3;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_kv", keys_valid, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk("midrst_k0", k0, '0);
        chk("midrst_k1", k1, '0);
        chk("midrst_slot3", rd_key, '0);
        @(negedge clk);
        asy_reset = 1'b0;
        @(negedge clk);
        run_expand("postrst", key_a, cyc);
        chki("postrst_latency", cyc, 10);
        @(negedge clk);
        verify_slots("postrst");

        // -------- back-to-back start on the done cycle --------
        cnt0 = done_cnt;
        run_expand("b2b_a", key_b, cyc);
        chki("b2b_a_latency", cyc, 10);
        model_expand(key_a);
        start = 1'b1;
        key_in = key_a;
        @(negedge clk);
        start = 1'b0;
        chk1("b2b_kv_drop", keys_valid, 1'b0);
        chk1("b2b_busy", busy, 1'b1);
        chk("b2b_k0", k0, key_a);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chki("b2b_b_latency", cyc, 10);
        @(negedge clk);
        chki("b2b_done_count", done_cnt - cnt0, 2);
        verify_slots("b2b");

`ifdef KEY_EXP_ZEROIZE_EN
        // -------- zeroize with start at cycle 7 --------
        start = 1'b1;
        key_in = key_b;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        zeroize = 1'b1;
        start = 1'b1;
        key_in = key_a;
        @(negedge clk);
        zeroize = 1'b0;
        start = 1'b0;
        cnt0 = done_cnt;
        chk1("zer_busy", busy, 1'b0);
        chk1("zer_kv", keys_valid, 1'b0);
        chk("zer_k0", k0, '0);
        chk("zer_k1", k1, '0);
        rd_idx = 4'd5;
        #1;
        chk("zer_slot5", rd_key, '0);
        repeat (12) @(negedge clk);
        chki("zer_no_done", done_cnt - cnt0, 0);
        run_expand("postzer", key_b, cyc);
        chki("postzer_latency", cyc, 10);
        @(negedge clk);
        verify_slots("postzer");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
- Iterative AES-128 key schedule that sits directly upstream of first_round and the later round stages.
- Accepts a 128-bit cipher key on a start pulse and generates round keys k0..k10, one per clock, into an internal 11-entry key store.
- Drives k0/k1 straight to first_round.
- Exposes an indexed read port so later round stages can fetch k2..k10.

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128, other values unsupported.
- KEY_W, 128, cipher key and round key width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- asy_reset  input  1  asynchronous active-high reset.
- start  input  1  single-cycle request to expand key_in; sampled only in IDLE.
- key_in  input  128  cipher key; [127:120] = byte 0 (FIPS-197 order), w0 = [127:96].
- rd_idx  input  4  round-key select for rd_key.
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when k10 has been written.
- keys_valid  output  1  high while all 11 slots hold keys of the current cipher key.
- k0  output  128  slot 0 (first_round k0).
- k1  output  128  slot 1 (first_round k1).
- rd_key  output  128  slot[rd_idx]; combinational read.

Behaviour:
- Reset: asynchronous, active-high on asy_reset, applied to every register in the block.
  - While asy_reset is high: FSM=IDLE, rnd=0, all 11 slots=0, busy=0, done=0, keys_valid=0, so k0=k1=rd_key=0.
  - Reset mid-expansion aborts the expansion and clears all of the above; no partial key survives.
- FSM states are IDLE and EXPAND.
- IDLE:
  - start=1 at edge E0: slot0<=key_in, rnd<=1, rcon<=8'h01, busy<=1, keys_valid<=0, state<=EXPAND.
- EXPAND:
  - At each edge Ei (i=1..10): slot[i] <= next(slot[i-1], rcon), rcon <= xtime(rcon), rnd <= rnd+1.
  - next(): temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - xtime sequence: 01,02,04,08,10,20,40,80,1B,36.
  - At E10: state<=IDLE, busy<=0, done<=1 for exactly one cycle, keys_valid<=1.
- Latency and availability:
  - start to done is 10 cycles.
  - k0 is valid the cycle after E0; k1 is valid the cycle after E1.
  - first_round may begin one cycle after E1.
- start handling:
  - start while busy is ignored; the expansion in progress is not disturbed.
  - start in the same cycle as done (already in IDLE) is accepted normally and drops keys_valid.
  - start while keys_valid=1 restarts expansion, overwriting slots from 0 upward.
- rd_key: rd_idx 0..10 returns that slot; rd_idx 11..15 returns 128'h0.
- Slot contents are stable except during their own write edge.

Optional Feature:
- Macro: KEY_EXP_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit, sync, active-high).
  - zeroize=1 at an edge: all slots<=0, keys_valid<=0, busy<=0, done<=0, state<=IDLE, in any state.
  - zeroize has priority over start in the same cycle.
- Undefined: no port is added and no zeroize logic is present; key material is cleared only by asy_reset or by overwrite on a new start.

Decomposition:
- Package aes_key_pkg holds:
  - SBOX[256] constant.
  - NR=10, NK=4.
  - xtime function.
  - State enum {IDLE, EXPAND}.
- Sub-module sub_word: combinational 32-bit SubWord built from four SBOX lookups. It is instantiated once and reused each EXPAND cycle.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c -> done 10 cycles after start; k1=a0fafe1788542cb123a339392a6c7605; rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key all-zero -> k1=62636363626363636263636362636363; slot10=b4ef5bcb3e92e21123e951cf6f8f188e; rd_idx=12 gives 0.
- Second start 4 cycles into an expansion with a different key -> ignored; done still comes at cycle 10 and slots match the first key.
- asy_reset pulse at EXPAND cycle 5 (asserted between edges) -> outputs 0 immediately; after release, a new start completes in 10 cycles with correct keys.
- Back-to-back: start on the cycle done=1 -> keys_valid falls, second key completes 10 cycles later, done pulses twice total.
- With KEY_EXP_ZEROIZE_EN: zeroize at cycle 7 together with start -> all slots 0, idle, no done; a new start later completes normally.
